// File: rtl/led_scan_controller_if.sv
// ----------------------------------------------------------------------------
// led_scan_controller_if
//
// Bundles the scan controller's outputs: the pixel_generator index bus and
// the panel connector signals.
//   col_count   [4:0]  column index to pixel_generator
//   row_count   [2:0]  row-pair index to pixel_generator
//   panel_clk          panel shift clock
//   panel_lat          panel latch, active high
//   panel_oe_n         panel output enable, active low
//   panel_addr  [2:0]  panel row address
//   frame_done         one-cycle pulse at the end of the last row's display
//
// Modports: master (driven by the scan controller), slave (observers).
// ----------------------------------------------------------------------------
interface led_scan_controller_if;
    logic [4:0] col_count;
    logic [2:0] row_count;
    logic       panel_clk;
    logic       panel_lat;
    logic       panel_oe_n;
    logic [2:0] panel_addr;
    logic       frame_done;

    modport master (
        output col_count,
        output row_count,
        output panel_clk,
        output panel_lat,
        output panel_oe_n,
        output panel_addr,
        output frame_done
    );

    modport slave (
        input col_count,
        input row_count,
        input panel_clk,
        input panel_lat,
        input panel_oe_n,
        input panel_addr,
        input frame_done
    );
endinterface

// File: rtl/led_scan_controller.sv
// ----------------------------------------------------------------------------
// led_scan_controller
//
// Sequences an RGB LED matrix panel scan. Per row: shift COLS columns with
// the panel blanked, one BLANK cycle that loads the row address, LATCH for
// LATCH_CYCLES, then DISPLAY for DISPLAY_CYCLES with the panel enabled.
// Runs through ROWS row pairs per frame and pulses frame_done after the last.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   enable      run scan (level); a row in progress always completes
//   brightness  [7:0] display duty, only with LED_SCAN_BRIGHTNESS_EN defined
//   scan        led_scan_controller_if.master: pixel index + panel signals
//
// Optional feature macro: LED_SCAN_BRIGHTNESS_EN. When defined, panel_oe_n is
// low only for the first brightness*(DISPLAY_CYCLES/256) cycles of DISPLAY;
// otherwise it is low for the whole DISPLAY state.
//
// All outputs are registered; their next values are derived from the
// next-state signals so each output lines up with the state it belongs to.
// ----------------------------------------------------------------------------
module led_scan_controller #(
    parameter int unsigned COLS           = 32,
    parameter int unsigned ROWS           = 8,
    parameter int unsigned CLK_DIV        = 2,
    parameter int unsigned LATCH_CYCLES   = 2,
    parameter int unsigned DISPLAY_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [7:0]            brightness,
`endif
    led_scan_controller_if.master scan
);

    localparam int unsigned PW = $clog2(2 * CLK_DIV);
    localparam int unsigned LW = $clog2(LATCH_CYCLES) + 1;
    localparam int unsigned DW = $clog2(DISPLAY_CYCLES);

    localparam logic [PW-1:0] P_LAST    = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] P_HIGH    = PW'(CLK_DIV);
    localparam logic [4:0]    COL_LAST  = 5'(COLS - 1);
    localparam logic [2:0]    ROW_LAST  = 3'(ROWS - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(LATCH_CYCLES - 1);
    localparam logic [DW-1:0] DISP_LAST = DW'(DISPLAY_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StBlank,
        StLatch,
        StDisplay
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [4:0]    col_q, col_d;
    logic [2:0]    row_q, row_d;
    logic [2:0]    addr_q, addr_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [DW-1:0] disp_q, disp_d;
    logic          frame_done_q, frame_done_d;
    logic          panel_clk_q, panel_clk_d;
    logic          panel_lat_q, panel_lat_d;
    logic          panel_oe_n_q, panel_oe_n_d;
    logic          display_on;

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        col_d        = col_q;
        row_d        = row_q;
        addr_d       = addr_q;
        lat_cnt_d    = lat_cnt_q;
        disp_d       = disp_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StShift;
                    p_d     = '0;
                    col_d   = '0;
                end
            end
            StShift: begin
                if (p_q == P_LAST) begin
                    p_d = '0;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = StBlank;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            StBlank: begin
                addr_d    = row_q;
                lat_cnt_d = '0;
                state_d   = StLatch;
            end
            StLatch: begin
                if (lat_cnt_q == LAT_LAST) begin
                    lat_cnt_d = '0;
                    disp_d    = '0;
                    state_d   = StDisplay;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            StDisplay: begin
                if (disp_q == DISP_LAST) begin
                    disp_d       = '0;
                    row_d        = (row_q == ROW_LAST) ? 3'd0 : row_q + 3'd1;
                    frame_done_d = (row_q == ROW_LAST);
                    state_d      = enable ? StShift : StIdle;
                end else begin
                    disp_d = disp_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [7:0]  bright_q, bright_d;
    logic [DW:0] on_limit;

    // Brightness is captured on the edge entering DISPLAY so the whole row
    // uses one duty value; the first DISPLAY cycle already sees the new value.
    always_comb begin
        bright_d = bright_q;
        if (state_d == StDisplay && state_q != StDisplay) begin
            bright_d = brightness;
        end
        on_limit   = (DW + 1)'(bright_d) * (DW + 1)'(DISPLAY_CYCLES / 256);
        display_on = (state_d == StDisplay) && ({1'b0, disp_d} < on_limit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bright_q <= '0;
        end else begin
            bright_q <= bright_d;
        end
    end
`else
    always_comb begin
        display_on = (state_d == StDisplay);
    end
`endif

    // Registered outputs follow the next state
    always_comb begin
        panel_clk_d  = (state_d == StShift) && (p_d >= P_HIGH);
        panel_lat_d  = (state_d == StLatch);
        panel_oe_n_d = !display_on;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            p_q          <= '0;
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            lat_cnt_q    <= '0;
            disp_q       <= '0;
            frame_done_q <= 1'b0;
            panel_clk_q  <= 1'b0;
            panel_lat_q  <= 1'b0;
            panel_oe_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            lat_cnt_q    <= lat_cnt_d;
            disp_q       <= disp_d;
            frame_done_q <= frame_done_d;
            panel_clk_q  <= panel_clk_d;
            panel_lat_q  <= panel_lat_d;
            panel_oe_n_q <= panel_oe_n_d;
        end
    end

    assign scan.col_count  = col_q;
    assign scan.row_count  = row_q;
    assign scan.panel_addr = addr_q;
    assign scan.panel_clk  = panel_clk_q;
    assign scan.panel_lat  = panel_lat_q;
    assign scan.panel_oe_n = panel_oe_n_q;
    assign scan.frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_led_scan_controller
//
// Drives randomized enable (and brightness when LED_SCAN_BRIGHTNESS_EN is
// defined) and compares every cycle against a row-timeline reference model:
// each row is a position t in 0..ROW_PERIOD-1 and the expected outputs are
// computed arithmetically from t. Directed phases cover frame spacing, the
// enable-drop resume and an asynchronous reset during LATCH.
// ----------------------------------------------------------------------------
module tb_led_scan_controller;

    localparam int COLS           = 32;
    localparam int ROWS           = 8;
    localparam int CLK_DIV        = 2;
    localparam int LATCH_CYCLES   = 2;
    localparam int DISPLAY_CYCLES = 256;
    localparam int SHIFT_LEN      = COLS * 2 * CLK_DIV;
    localparam int DISP_START     = SHIFT_LEN + 1 + LATCH_CYCLES;
    localparam int ROW_PERIOD     = DISP_START + DISPLAY_CYCLES;
    localparam int FRAME_PERIOD   = ROWS * ROW_PERIOD;
`ifdef LED_SCAN_BRIGHTNESS_EN
    localparam int ON_PER_ROW     = 64 * (DISPLAY_CYCLES / 256);
`else
    localparam int ON_PER_ROW     = DISPLAY_CYCLES;
`endif

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b0;
`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [7:0] brightness = 8'd0;
`endif

    int checks   = 0;
    int failures = 0;

    led_scan_controller_if scan ();

    led_scan_controller #(
        .COLS           (COLS),
        .ROWS           (ROWS),
        .CLK_DIV        (CLK_DIV),
        .LATCH_CYCLES   (LATCH_CYCLES),
        .DISPLAY_CYCLES (DISPLAY_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
`ifdef LED_SCAN_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .scan       (scan)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit m_idle;
    int m_t;
    int m_row;
    int m_addr;
    bit m_done;
    int m_bright;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle   = 1'b1;
        m_t      = 0;
        m_row    = 0;
        m_addr   = 0;
        m_done   = 1'b0;
        m_bright = 0;
    endtask

    task automatic model_step(input bit en, input int br);
        m_done = 1'b0;
        if (m_idle) begin
            if (en) begin
                m_idle = 1'b0;
                m_t    = 0;
            end
        end else if (m_t == ROW_PERIOD - 1) begin
            m_done = (m_row == ROWS - 1);
            m_row  = (m_row + 1) % ROWS;
            if (en) m_t = 0;
            else    m_idle = 1'b1;
        end else begin
            if (m_t == SHIFT_LEN) m_addr = m_row;
            m_t++;
            if (m_t == DISP_START) m_bright = br;
        end
    endtask

    function automatic logic [14:0] model_outs();
        int  col;
        int  d;
        bit  pclk;
        bit  lat;
        bit  on;
        col  = (!m_idle && m_t < SHIFT_LEN) ? m_t / (2 * CLK_DIV) : 0;
        pclk = !m_idle && m_t < SHIFT_LEN && (m_t % (2 * CLK_DIV)) >= CLK_DIV;
        lat  = !m_idle && m_t > SHIFT_LEN && m_t < DISP_START;
        d    = m_t - DISP_START;
        on   = !m_idle && d >= 0 && d < DISPLAY_CYCLES;
`ifdef LED_SCAN_BRIGHTNESS_EN
        on   = on && (d < m_bright * (DISPLAY_CYCLES / 256));
`endif
        return {5'(col), 3'(m_row), pclk, lat, !on, 3'(m_addr), m_done};
    endfunction

    function automatic logic [14:0] dut_outs();
        return {scan.col_count, scan.row_count, scan.panel_clk, scan.panel_lat,
                scan.panel_oe_n, scan.panel_addr, scan.frame_done};
    endfunction

    // Called at a negedge: compare, drive, step the model across the posedge.
    task automatic cycle(input bit en);
        check("outputs", 32'(dut_outs()), 32'(model_outs()));
        enable = en;
        @(posedge clk);
`ifdef LED_SCAN_BRIGHTNESS_EN
        model_step(en, int'(brightness));
`else
        model_step(en, 0);
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        enable = 1'b0;
        reset  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int  pulses[$];
        int  oe_low;
        int  cyc;
        int  guard;
        bit  en;
        bit  counting;

        model_reset();
        @(negedge clk);
        do_reset();
        check("reset_oe_n", 32'(scan.panel_oe_n), 32'd1);
        check("reset_outs", 32'(dut_outs()), 32'(15'b000000_00_1_000_0));

        // Phase 1: enable held, three frames
`ifdef LED_SCAN_BRIGHTNESS_EN
        brightness = 8'd64;
`endif
        oe_low   = 0;
        counting = 1'b0;
        for (cyc = 0; cyc < 3 * FRAME_PERIOD + 20; cyc++) begin
            if (scan.frame_done) begin
                pulses.push_back(cyc);
                counting = (pulses.size() == 1);
            end
            if (counting && !scan.panel_oe_n) oe_low++;
            cycle(1'b1);
        end
        check("frame_count", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            check("frame_gap1", 32'(pulses[1] - pulses[0]), 32'(FRAME_PERIOD));
            check("frame_gap2", 32'(pulses[2] - pulses[1]), 32'(FRAME_PERIOD));
        end
        check("oe_low_frame", 32'(oe_low), 32'(ROWS * ON_PER_ROW));

        // Phase 2: random enable (and brightness)
        en = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 299) == 0) en = !en;
`ifdef LED_SCAN_BRIGHTNESS_EN
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 3))
                    0:       brightness = 8'd0;
                    1:       brightness = 8'd64;
                    2:       brightness = 8'd255;
                    default: brightness = 8'($urandom_range(0, 255));
                endcase
            end
`endif
            cycle(en);
        end

        // Phase 3: drop enable during row 3 SHIFT, then resume
        do_reset();
        guard = 0;
        while (!(!m_idle && m_row == 3 && m_t == 50) && guard < 2 * FRAME_PERIOD) begin
            cycle(1'b1);
            guard++;
        end
        check("reach_row3", 32'(guard < 2 * FRAME_PERIOD), 32'd1);
        guard = 0;
        while (!m_idle && guard < 2 * ROW_PERIOD) begin
            cycle(1'b0);
            guard++;
        end
        check("reach_idle", 32'(guard < 2 * ROW_PERIOD), 32'd1);
        repeat (5) cycle(1'b0);
        check("idle_row", 32'(scan.row_count), 32'd4);
        check("idle_oe_n", 32'(scan.panel_oe_n), 32'd1);
        repeat (SHIFT_LEN + 3) cycle(1'b1);
        check("resume_addr", 32'(scan.panel_addr), 32'd4);

        // Phase 4: async reset in the middle of LATCH
        do_reset();
        guard = 0;
        while (!(!m_idle && m_row == 2 && m_t == SHIFT_LEN + 1) && guard < FRAME_PERIOD) begin
            cycle(1'b1);
            guard++;
        end
        check("reach_latch", 32'(guard < FRAME_PERIOD), 32'd1);
        check("lat_before_rst", 32'(scan.panel_lat), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_lat", 32'(scan.panel_lat), 32'd0);
        check("rst_oe_n", 32'(scan.panel_oe_n), 32'd1);
        check("rst_row", 32'(scan.row_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (ROW_PERIOD + 10) cycle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
